fb_stream_reader: RTL

FB_STREAM_READER -- requirements
Module: fb_stream_reader

---
 rtl/fb_stream_pkg.sv | 23 ++
 rtl/fb_sync_fifo.sv | 61 ++++++
 rtl/fb_stream_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_stream_pkg.sv
// Shared types and helpers for the frame-buffer stream reader:
// FSM state encoding, RGB565 field widths and frame sizing.
package fb_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SYNC,
      ST_FETCH,
      ST_DONE
   } fb_state_t;

   localparam int unsigned RGB_R_W = 5;
   localparam int unsigned RGB_G_W = 6;
   localparam int unsigned RGB_B_W = 5;
   localparam int unsigned PIXEL_W = RGB_R_W + RGB_G_W + RGB_B_W;

   // Each 32-bit memory word carries two RGB565 pixels.
   function automatic int unsigned words_per_frame(input int unsigned h_pixels,
                                                   input int unsigned v_lines);
      return (h_pixels * v_lines) / 2;
   endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO with fall-through read data and a synchronous flush.
// DEPTH must be a power of two; writes when full and reads when empty are ignored.
module fb_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   input  logic                     i_Flush,
   input  logic                     i_Wr_En,
   input  logic [WIDTH-1:0]         i_Wr_Data,
   input  logic                     i_Rd_En,
   output logic [WIDTH-1:0]         o_Rd_Data,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             wr_fire;
   logic             rd_fire;

   assign full      = count[AW];
   assign o_Empty   = (count == '0);
   assign o_Count   = count;
   assign o_Rd_Data = mem[rd_ptr];
   assign wr_fire   = i_Wr_En && !full && !i_Flush;
   assign rd_fire   = i_Rd_En && !o_Empty && !i_Flush;

   // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage array, written only on an accepted write.
   always_ff @(posedge i_Clock) begin
      if (wr_fire) mem[wr_ptr] <= i_Wr_Data;
   end

endmodule

// File: rtl/fb_stream_reader.sv
// Frame-buffer stream reader: fetches a frame of 32-bit words from memory
// after each frame-sync edge and streams them out as RGB565 pixels.
// Optional feature macro FB_STREAM_READER_SWAP_EN adds a double-buffer base
// address swap (i_Swap_Addr/i_Swap_Valid), applied at the next fsync edge.
module fb_stream_reader
   import fb_stream_pkg::*;
#(
   parameter logic [31:0] FB_BASE_ADDR = 32'h8000_0000,
   parameter int unsigned H_PIXELS     = 640,
   parameter int unsigned V_LINES      = 480,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   input  logic               i_Enable,
   input  logic               i_Fsync,
   output logic               o_Mem_Req_Valid,
   output logic [31:0]        o_Mem_Req_Addr,
   input  logic               i_Mem_Req_Ready,
   input  logic               i_Mem_Rsp_Valid,
   input  logic [31:0]        i_Mem_Rsp_Data,
   output logic [PIXEL_W-1:0] m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast
`ifdef FB_STREAM_READER_SWAP_EN
   ,
   input  logic [31:0]        i_Swap_Addr,
   input  logic               i_Swap_Valid
`endif
);

   localparam int unsigned WORDS = words_per_frame(H_PIXELS, V_LINES);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PW    = $clog2(H_PIXELS);
   localparam int unsigned LW    = $clog2(V_LINES + 1);

   localparam logic [CW:0]   DEPTH_V  = FIFO_DEPTH[CW:0];
   localparam logic [31:0]   LAST_REQ = 32'(WORDS - 1);
   localparam logic [PW-1:0] H_LAST   = PW'(H_PIXELS - 1);
   localparam logic [LW-1:0] V_END    = LW'(V_LINES);

   fb_state_t            state, state_nxt;
   logic                 fsync_q;
   logic                 fsync_edge;
   logic                 restart;
   logic                 abort;
   logic                 accept;
   logic [31:0]          req_cnt;
   logic [31:0]          base_sel;
   logic [CW-1:0]        outstanding;
   logic [CW-1:0]        discard;
   logic [CW-1:0]        out_nxt;
   logic [CW:0]          in_flight;
   logic                 rsp_keep;
   logic                 fifo_rd;
   logic                 fifo_empty;
   logic [31:0]          fifo_data;
   logic [CW-1:0]        fifo_count;
   logic                 load_slot;
   logic                 hi_pending;
   logic [PIXEL_W-1:0]   hi_word;
   logic [PW-1:0]        pix_cnt;
   logic [LW-1:0]        line_cnt;

   assign fsync_edge = i_Fsync && !fsync_q;
   assign restart    = i_Enable && fsync_edge && (state != ST_IDLE);
   // Any restart or disable throws away everything in flight for the frame.
   assign abort      = !i_Enable || restart;
   assign accept     = o_Mem_Req_Valid && i_Mem_Req_Ready;
   assign out_nxt    = outstanding + CW'(accept) - CW'(i_Mem_Rsp_Valid);
   assign in_flight  = {1'b0, outstanding} + {1'b0, fifo_count};
   assign rsp_keep   = i_Mem_Rsp_Valid && (discard == '0) && !abort;
   assign load_slot  = !m_axis_tvalid || m_axis_tready;
   assign fifo_rd    = load_slot && !hi_pending && !fifo_empty && !abort &&
                       (line_cnt != V_END);

`ifdef FB_STREAM_READER_SWAP_EN
   logic [31:0] pending_base;

   // Latch the most recent swap request; it takes effect at the next restart.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset)           pending_base <= FB_BASE_ADDR;
      else if (i_Swap_Valid) pending_base <= i_Swap_Addr;
   end

   assign base_sel = pending_base;
`else
   assign base_sel = FB_BASE_ADDR;
`endif

   // Registered fsync copy for rising-edge detection.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) fsync_q <= 1'b0;
      else         fsync_q <= i_Fsync;
   end

   // FSM state register.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state and request-valid decode; requests are credit-limited by FIFO space.
   always_comb begin
      state_nxt       = state;
      o_Mem_Req_Valid = 1'b0;
      if (!i_Enable) begin
         state_nxt = ST_IDLE;
      end else if (restart) begin
         state_nxt = ST_FETCH;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ST_WAIT_SYNC;
            ST_FETCH: begin
               o_Mem_Req_Valid = (in_flight < DEPTH_V);
               if (o_Mem_Req_Valid && i_Mem_Req_Ready && (req_cnt == LAST_REQ))
                  state_nxt = ST_DONE;
            end
            default:  ;
         endcase
      end
   end

   // Request address and accepted-request count for the current frame.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         o_Mem_Req_Addr <= FB_BASE_ADDR;
         req_cnt        <= '0;
      end else if (restart) begin
         o_Mem_Req_Addr <= base_sel;
         req_cnt        <= '0;
      end else if (accept) begin
         o_Mem_Req_Addr <= o_Mem_Req_Addr + 32'd4;
         req_cnt        <= req_cnt + 32'd1;
      end
   end

   // Outstanding-request tracking; on abort every still-pending response is marked stale.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= out_nxt;
         if (abort)
            discard <= out_nxt;
         else if (i_Mem_Rsp_Valid && (discard != '0))
            discard <= discard - 1'b1;
      end
   end

   fb_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Reset   (i_Reset),
      .i_Flush   (abort),
      .i_Wr_En   (rsp_keep),
      .i_Wr_Data (i_Mem_Rsp_Data),
      .i_Rd_En   (fifo_rd),
      .o_Rd_Data (fifo_data),
      .o_Empty   (fifo_empty),
      .o_Count   (fifo_count)
   );

   // Output stage: split each word low half first, tag end of line as pixels are loaded.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         hi_pending    <= 1'b0;
         hi_word       <= '0;
         pix_cnt       <= '0;
         line_cnt      <= '0;
      end else if (abort) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         hi_pending    <= 1'b0;
         pix_cnt       <= '0;
         line_cnt      <= '0;
      end else if (load_slot) begin
         if (hi_pending || fifo_rd) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hi_pending ? hi_word : fifo_data[PIXEL_W-1:0];
            if (!hi_pending) hi_word <= fifo_data[31:PIXEL_W];
            hi_pending    <= !hi_pending;
            m_axis_tlast  <= (pix_cnt == H_LAST);
            if (pix_cnt == H_LAST) begin
               pix_cnt  <= '0;
               line_cnt <= line_cnt + 1'b1;
            end else begin
               pix_cnt  <= pix_cnt + 1'b1;
            end
         end else begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule
